// File: rtl/nv_nvdla_cdp_dp_intp_req.sv
// ============================================================================
// Module   : nv_nvdla_cdp_dp_intp_req
// Brief    : CDP interpolation request side: LUT index/fraction, LUT fetch,
//            operand hand-off and saturating underflow/overflow counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nv_nvdla_cdp_dp_intp_req #(
   parameter int LUT_DEPTH = 65,
   parameter int LUT_AW    = 7
) (
   input  logic              nvdla_core_clk,
   input  logic              nvdla_core_rst,
   input  logic              smp_in_vld,
   output logic              smp_in_rdy,
   input  logic [31:0]       smp_in_pd,
   input  logic [31:0]       cfg_start,
   input  logic [4:0]        cfg_index_shift,
   input  logic [5:0]        cfg_out_shift,
   input  logic              cfg_cnt_clr,
   output logic              lut_req_vld,
   input  logic              lut_req_rdy,
   output logic [LUT_AW-1:0] lut_req_idx0,
   output logic [LUT_AW-1:0] lut_req_idx1,
   input  logic              lut_rsp_vld,
   output logic              lut_rsp_rdy,
   input  logic [15:0]       lut_rsp_data0,
   input  logic [15:0]       lut_rsp_data1,
   output logic              interp_in_vld,
   input  logic              interp_in_rdy,
   output logic [38:0]       interp_in0_pd,
   output logic [37:0]       interp_in1_pd,
   output logic [16:0]       interp_in_pd,
   output logic [16:0]       interp_in_scale,
   output logic [5:0]        interp_in_shift,
   output logic              interp_in_uflow,
   output logic              interp_in_oflow,
   output logic [31:0]       uflow_cnt,
   output logic [31:0]       oflow_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_OUT  = 2'd3
   } state_t;

   localparam logic [31:0]       c_max_raw = 32'(LUT_DEPTH - 1);
   localparam logic [LUT_AW-1:0] c_max_idx = LUT_AW'(LUT_DEPTH - 1);

   state_t            r_state;
   state_t            w_state_nxt;

   logic [32:0]       w_diff;
   logic              w_uflow;
   logic              w_oflow;
   logic [31:0]       w_raw;
   logic [15:0]       w_frac;
   logic [LUT_AW-1:0] w_idx0;
   logic [LUT_AW-1:0] w_idx1;

   logic              w_smp_hs;
   logic              w_rsp_hs;
   logic              w_out_hs;

   logic [LUT_AW-1:0] r_idx0;
   logic [LUT_AW-1:0] r_idx1;
   logic [15:0]       r_frac;
   logic [5:0]        r_oshift;
   logic              r_uflow;
   logic              r_oflow;
   logic [38:0]       r_in0;
   logic [37:0]       r_in1;
   logic [16:0]       r_inpd;
   logic [31:0]       r_uflow_cnt;
   logic [31:0]       r_oflow_cnt;

   // 33-bit signed difference so that full-range operands never wrap
   always_comb begin
      w_diff  = {smp_in_pd[31], smp_in_pd} - {cfg_start[31], cfg_start};
      w_uflow = w_diff[32];
      w_raw   = w_diff[31:0] >> cfg_index_shift;
      w_frac  = 16'({w_diff[31:0], 16'b0} >> cfg_index_shift);
      w_oflow = !w_uflow && (w_raw >= c_max_raw);
      w_idx0  = w_raw[LUT_AW-1:0];
      w_idx1  = w_raw[LUT_AW-1:0] + LUT_AW'(1);
      if (w_uflow) begin
         w_idx0 = '0;
         w_idx1 = '0;
         w_frac = '0;
      end else if (w_oflow) begin
         w_idx0 = c_max_idx;
         w_idx1 = c_max_idx;
         w_frac = '0;
      end
   end

   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      smp_in_rdy    = 1'b0;
      lut_req_vld   = 1'b0;
      lut_rsp_rdy   = 1'b0;
      interp_in_vld = 1'b0;
      case (r_state)
         S_IDLE: begin
            smp_in_rdy = !nvdla_core_rst;
            if (smp_in_vld) w_state_nxt = S_REQ;
         end
         S_REQ: begin
            lut_req_vld = 1'b1;
            if (lut_req_rdy) w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            lut_rsp_rdy = 1'b1;
            if (lut_rsp_vld) w_state_nxt = S_OUT;
         end
         S_OUT: begin
            interp_in_vld = 1'b1;
            if (interp_in_rdy) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_smp_hs = (r_state == S_IDLE) && smp_in_vld;
   assign w_rsp_hs = (r_state == S_WAIT) && lut_rsp_vld;
   assign w_out_hs = (r_state == S_OUT) && interp_in_rdy;

   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         r_idx0   <= '0;
         r_idx1   <= '0;
         r_frac   <= '0;
         r_oshift <= '0;
         r_uflow  <= 1'b0;
         r_oflow  <= 1'b0;
      end else if (w_smp_hs) begin
         r_idx0   <= w_idx0;
         r_idx1   <= w_idx1;
         r_frac   <= w_frac;
         r_oshift <= cfg_out_shift;
         r_uflow  <= w_uflow;
         r_oflow  <= w_oflow;
      end
   end

   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         r_in0  <= '0;
         r_in1  <= '0;
         r_inpd <= '0;
      end else if (w_rsp_hs) begin
         r_in0  <= {{23{lut_rsp_data0[15]}}, lut_rsp_data0};
         r_in1  <= {{22{lut_rsp_data1[15]}}, lut_rsp_data1};
         r_inpd <= {lut_rsp_data0[15], lut_rsp_data0};
      end
   end

   // Clear has priority over a coincident increment
   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         r_uflow_cnt <= '0;
         r_oflow_cnt <= '0;
      end else if (cfg_cnt_clr) begin
         r_uflow_cnt <= '0;
         r_oflow_cnt <= '0;
      end else if (w_out_hs) begin
         if (r_uflow && !(&r_uflow_cnt)) r_uflow_cnt <= r_uflow_cnt + 32'd1;
         if (r_oflow && !(&r_oflow_cnt)) r_oflow_cnt <= r_oflow_cnt + 32'd1;
      end
   end

   assign lut_req_idx0    = r_idx0;
   assign lut_req_idx1    = r_idx1;
   assign interp_in0_pd   = r_in0;
   assign interp_in1_pd   = r_in1;
   assign interp_in_pd    = r_inpd;
   assign interp_in_scale = {1'b0, r_frac};
   assign interp_in_shift = r_oshift;
   assign interp_in_uflow = r_uflow;
   assign interp_in_oflow = r_oflow;
   assign uflow_cnt       = r_uflow_cnt;
   assign oflow_cnt       = r_oflow_cnt;

endmodule

`default_nettype wire

// File: tb/tb_nv_nvdla_cdp_dp_intp_req.sv
// ============================================================================
// Module   : tb_nv_nvdla_cdp_dp_intp_req
// Brief    : Directed scoreboard bench for the CDP interpolation request block.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_nv_nvdla_cdp_dp_intp_req;

   localparam int LUT_DEPTH = 65;
   localparam int LUT_AW    = 7;

   logic              nvdla_core_clk;
   logic              nvdla_core_rst;
   logic              smp_in_vld;
   logic              smp_in_rdy;
   logic [31:0]       smp_in_pd;
   logic [31:0]       cfg_start;
   logic [4:0]        cfg_index_shift;
   logic [5:0]        cfg_out_shift;
   logic              cfg_cnt_clr;
   logic              lut_req_vld;
   logic              lut_req_rdy;
   logic [LUT_AW-1:0] lut_req_idx0;
   logic [LUT_AW-1:0] lut_req_idx1;
   logic              lut_rsp_vld;
   logic              lut_rsp_rdy;
   logic [15:0]       lut_rsp_data0;
   logic [15:0]       lut_rsp_data1;
   logic              interp_in_vld;
   logic              interp_in_rdy;
   logic [38:0]       interp_in0_pd;
   logic [37:0]       interp_in1_pd;
   logic [16:0]       interp_in_pd;
   logic [16:0]       interp_in_scale;
   logic [5:0]        interp_in_shift;
   logic              interp_in_uflow;
   logic              interp_in_oflow;
   logic [31:0]       uflow_cnt;
   logic [31:0]       oflow_cnt;

   nv_nvdla_cdp_dp_intp_req #(.LUT_DEPTH(LUT_DEPTH), .LUT_AW(LUT_AW)) dut (
      .nvdla_core_clk  (nvdla_core_clk),
      .nvdla_core_rst  (nvdla_core_rst),
      .smp_in_vld      (smp_in_vld),
      .smp_in_rdy      (smp_in_rdy),
      .smp_in_pd       (smp_in_pd),
      .cfg_start       (cfg_start),
      .cfg_index_shift (cfg_index_shift),
      .cfg_out_shift   (cfg_out_shift),
      .cfg_cnt_clr     (cfg_cnt_clr),
      .lut_req_vld     (lut_req_vld),
      .lut_req_rdy     (lut_req_rdy),
      .lut_req_idx0    (lut_req_idx0),
      .lut_req_idx1    (lut_req_idx1),
      .lut_rsp_vld     (lut_rsp_vld),
      .lut_rsp_rdy     (lut_rsp_rdy),
      .lut_rsp_data0   (lut_rsp_data0),
      .lut_rsp_data1   (lut_rsp_data1),
      .interp_in_vld   (interp_in_vld),
      .interp_in_rdy   (interp_in_rdy),
      .interp_in0_pd   (interp_in0_pd),
      .interp_in1_pd   (interp_in1_pd),
      .interp_in_pd    (interp_in_pd),
      .interp_in_scale (interp_in_scale),
      .interp_in_shift (interp_in_shift),
      .interp_in_uflow (interp_in_uflow),
      .interp_in_oflow (interp_in_oflow),
      .uflow_cnt       (uflow_cnt),
      .oflow_cnt       (oflow_cnt)
   );

   initial nvdla_core_clk = 1'b0;
   always #5 nvdla_core_clk = ~nvdla_core_clk;

   typedef struct {
      logic [6:0]  idx0;
      logic [6:0]  idx1;
      logic [38:0] in0;
      logic [37:0] in1;
      logic [16:0] inpd;
      logic [16:0] scale;
      logic [5:0]  shift;
      logic        uf;
      logic        of;
   } exp_t;

   exp_t        sb_q[$];
   logic [15:0] lut_mem [0:LUT_DEPTH-1];
   logic [31:0] exp_ucnt;
   logic [31:0] exp_ocnt;
   int          compared;
   int          mismatched;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference index/fraction math done in 64-bit integers
   function automatic exp_t model(input logic [31:0] smp, input logic [31:0] start,
                                  input logic [4:0] ish, input logic [5:0] osh);
      exp_t   e;
      longint diff, raw, fr;
      logic [15:0] d0, d1;
      diff = longint'($signed(smp)) - longint'($signed(start));
      e.uf = 1'b0;
      e.of = 1'b0;
      if (diff < 0) begin
         e.uf = 1'b1; e.idx0 = 7'd0; e.idx1 = 7'd0; fr = 0;
      end else begin
         raw = diff >> ish;
         fr  = ((diff << 16) >> ish) & 64'hFFFF;
         if (raw >= LUT_DEPTH - 1) begin
            e.of = 1'b1; e.idx0 = 7'(LUT_DEPTH - 1); e.idx1 = 7'(LUT_DEPTH - 1); fr = 0;
         end else begin
            e.idx0 = 7'(raw); e.idx1 = 7'(raw + 1);
         end
      end
      d0      = lut_mem[e.idx0];
      d1      = lut_mem[e.idx1];
      e.in0   = 39'($signed(d0));
      e.in1   = 38'($signed(d1));
      e.inpd  = 17'($signed(d0));
      e.scale = 17'(fr);
      e.shift = osh;
      return e;
   endfunction

   task automatic chk_out(input string sfx, input exp_t e);
      chk({"in0_",   sfx}, 64'(interp_in0_pd),   64'(e.in0));
      chk({"in1_",   sfx}, 64'(interp_in1_pd),   64'(e.in1));
      chk({"inpd_",  sfx}, 64'(interp_in_pd),    64'(e.inpd));
      chk({"scale_", sfx}, 64'(interp_in_scale), 64'(e.scale));
      chk({"shift_", sfx}, 64'(interp_in_shift), 64'(e.shift));
      chk({"uf_",    sfx}, 64'(interp_in_uflow), 64'(e.uf));
      chk({"of_",    sfx}, 64'(interp_in_oflow), 64'(e.of));
   endtask

   task automatic chk_idle_outputs(input string sfx);
      chk({"req_vld_",  sfx}, 64'(lut_req_vld),   64'd0);
      chk({"idx0_",     sfx}, 64'(lut_req_idx0),  64'd0);
      chk({"idx1_",     sfx}, 64'(lut_req_idx1),  64'd0);
      chk({"rsp_rdy_",  sfx}, 64'(lut_rsp_rdy),   64'd0);
      chk({"out_vld_",  sfx}, 64'(interp_in_vld), 64'd0);
      chk({"in0_",      sfx}, 64'(interp_in0_pd), 64'd0);
      chk({"scale_",    sfx}, 64'(interp_in_scale), 64'd0);
      chk({"ucnt_",     sfx}, 64'(uflow_cnt),     64'd0);
      chk({"ocnt_",     sfx}, 64'(oflow_cnt),     64'd0);
   endtask

   // Drive a sample and carry it through request, response and output phases
   task automatic send_sample(input logic [31:0] smp, input logic [31:0] start,
                              input logic [4:0] ish, input logic [5:0] osh);
      sb_q.push_back(model(smp, start, ish, osh));
      @(negedge nvdla_core_clk);
      chk("smp_rdy_idle", 64'(smp_in_rdy), 64'd1);
      smp_in_vld      = 1'b1;
      smp_in_pd       = smp;
      cfg_start       = start;
      cfg_index_shift = ish;
      cfg_out_shift   = osh;
      @(posedge nvdla_core_clk);
      @(negedge nvdla_core_clk);
      smp_in_vld      = 1'b0;
      smp_in_pd       = $urandom;
      cfg_start       = $urandom;
      cfg_index_shift = 5'($urandom);
      cfg_out_shift   = 6'($urandom);
   endtask

   task automatic req_phase(input int req_stall);
      exp_t e;
      e = sb_q[0];
      chk("req_vld", 64'(lut_req_vld), 64'd1);
      chk("req_idx0", 64'(lut_req_idx0), 64'(e.idx0));
      chk("req_idx1", 64'(lut_req_idx1), 64'(e.idx1));
      chk("smp_rdy_busy", 64'(smp_in_rdy), 64'd0);
      lut_rsp_vld   = 1'b1;
      lut_rsp_data0 = 16'hDEAD;
      lut_rsp_data1 = 16'hBEEF;
      for (int i = 0; i < req_stall; i++) begin
         chk("early_rsp_rdy", 64'(lut_rsp_rdy), 64'd0);
         @(negedge nvdla_core_clk);
         chk("req_vld_hold", 64'(lut_req_vld), 64'd1);
         chk("req_idx0_hold", 64'(lut_req_idx0), 64'(e.idx0));
         chk("req_idx1_hold", 64'(lut_req_idx1), 64'(e.idx1));
      end
      lut_rsp_vld = 1'b0;
      lut_req_rdy = 1'b1;
      @(posedge nvdla_core_clk);
      @(negedge nvdla_core_clk);
      lut_req_rdy = 1'b0;
      chk("rsp_rdy_wait", 64'(lut_rsp_rdy), 64'd1);
   endtask

   task automatic rsp_out_phase(input int out_stall, input bit clr_at_out);
      exp_t e;
      lut_rsp_vld   = 1'b1;
      lut_rsp_data0 = lut_mem[lut_req_idx0];
      lut_rsp_data1 = lut_mem[lut_req_idx1];
      @(posedge nvdla_core_clk);
      @(negedge nvdla_core_clk);
      lut_rsp_vld   = 1'b0;
      lut_rsp_data0 = 16'($urandom);
      lut_rsp_data1 = 16'($urandom);
      chk("out_vld", 64'(interp_in_vld), 64'd1);
      chk("rsp_rdy_out", 64'(lut_rsp_rdy), 64'd0);
      if (sb_q.size() == 0) begin
         chk("sb_empty", 64'd1, 64'd0);
         return;
      end
      e = sb_q.pop_front();
      chk_out("out", e);
      for (int i = 0; i < out_stall; i++) begin
         @(negedge nvdla_core_clk);
         chk("out_vld_hold", 64'(interp_in_vld), 64'd1);
         chk("smp_rdy_stall", 64'(smp_in_rdy), 64'd0);
         chk_out("hold", e);
      end
      interp_in_rdy = 1'b1;
      cfg_cnt_clr   = clr_at_out;
      @(posedge nvdla_core_clk);
      if (clr_at_out) begin
         exp_ucnt = '0;
         exp_ocnt = '0;
      end else begin
         if (e.uf && exp_ucnt != 32'hFFFFFFFF) exp_ucnt = exp_ucnt + 32'd1;
         if (e.of && exp_ocnt != 32'hFFFFFFFF) exp_ocnt = exp_ocnt + 32'd1;
      end
      @(negedge nvdla_core_clk);
      interp_in_rdy = 1'b0;
      cfg_cnt_clr   = 1'b0;
      chk("uflow_cnt", 64'(uflow_cnt), 64'(exp_ucnt));
      chk("oflow_cnt", 64'(oflow_cnt), 64'(exp_ocnt));
      chk("out_vld_done", 64'(interp_in_vld), 64'd0);
      chk("smp_rdy_again", 64'(smp_in_rdy), 64'd1);
   endtask

   task automatic run_txn(input logic [31:0] smp, input logic [31:0] start,
                          input logic [4:0] ish, input logic [5:0] osh,
                          input int req_stall, input int out_stall, input bit clr_at_out);
      send_sample(smp, start, ish, osh);
      req_phase(req_stall);
      rsp_out_phase(out_stall, clr_at_out);
   endtask

   initial begin
      compared        = 0;
      mismatched      = 0;
      exp_ucnt        = '0;
      exp_ocnt        = '0;
      for (int i = 0; i < LUT_DEPTH; i++) lut_mem[i] = 16'(i * 37 - 900);
      lut_mem[3]      = 16'd100;
      lut_mem[4]      = 16'd200;
      lut_mem[10]     = 16'hFFFB;
      nvdla_core_rst  = 1'b1;
      smp_in_vld      = 1'b0;
      smp_in_pd       = '0;
      cfg_start       = '0;
      cfg_index_shift = '0;
      cfg_out_shift   = '0;
      cfg_cnt_clr     = 1'b0;
      lut_req_rdy     = 1'b0;
      lut_rsp_vld     = 1'b0;
      lut_rsp_data0   = '0;
      lut_rsp_data1   = '0;
      interp_in_rdy   = 1'b0;

      repeat (3) @(negedge nvdla_core_clk);
      chk_idle_outputs("reset");
      nvdla_core_rst = 1'b0;
      @(negedge nvdla_core_clk);
      chk("smp_rdy_after_reset", 64'(smp_in_rdy), 64'd1);

      // Nominal interpolation, minimum latency
      run_txn(32'h35, 32'h0, 5'd4, 6'd9, 0, 0, 1'b0);
      // Underflow
      run_txn(32'h80, 32'h100, 5'd4, 6'd3, 0, 0, 1'b0);
      // Overflow
      run_txn(32'd1000, 32'h0, 5'd0, 6'h3F, 0, 0, 1'b0);
      // Last in-range index and first overflowing value
      run_txn(32'd63, 32'h0, 5'd0, 6'd1, 0, 0, 1'b0);
      run_txn(32'd64, 32'h0, 5'd0, 6'd2, 0, 0, 1'b0);
      // Negative operands with a non-zero fraction
      run_txn(-32'sd50, -32'sd100, 5'd3, 6'd20, 0, 0, 1'b0);
      // Backpressure on both sides; entry 10 is -5
      run_txn(32'h2B, 32'h0, 5'd2, 6'd7, 5, 3, 1'b0);
      chk("neg_in0_const", 64'(interp_in0_pd), 64'h7FFFFFFFFB);

      // Reset while waiting for the LUT response
      send_sample(32'h35, 32'h0, 5'd4, 6'd5);
      req_phase(0);
      void'(sb_q.pop_back());
      nvdla_core_rst = 1'b1;
      exp_ucnt = '0;
      exp_ocnt = '0;
      @(negedge nvdla_core_clk);
      chk_idle_outputs("abort");
      nvdla_core_rst = 1'b0;
      lut_rsp_vld    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge nvdla_core_clk);
         chk("abort_no_out", 64'(interp_in_vld), 64'd0);
         chk("abort_no_req", 64'(lut_req_vld), 64'd0);
         chk("abort_smp_rdy", 64'(smp_in_rdy), 64'd1);
      end
      lut_rsp_vld = 1'b0;
      run_txn(32'h35, 32'h0, 5'd4, 6'd5, 1, 1, 1'b0);

      // Saturation and clear-wins
      run_txn(32'd500, 32'h0, 5'd1, 6'd0, 0, 0, 1'b0);
      @(negedge nvdla_core_clk);
      force dut.r_uflow_cnt = 32'hFFFFFFFF;
      #1;
      release dut.r_uflow_cnt;
      exp_ucnt = 32'hFFFFFFFF;
      @(negedge nvdla_core_clk);
      chk("ucnt_preset", 64'(uflow_cnt), 64'(exp_ucnt));
      run_txn(32'h0, 32'h10, 5'd2, 6'd0, 0, 0, 1'b0);
      run_txn(32'h0, 32'h10, 5'd2, 6'd0, 0, 1, 1'b1);

      chk("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/nv_nvdla_cdp_dp_intp_req.md
Name: nv_nvdla_cdp_dp_intp_req

Overview:
Initiator side of the CDP interpolation interface. It accepts one raw sample at a time and computes the LUT index pair and the 16-bit fraction from a configured start value and index shift. It fetches the two LUT entries over a valid/ready request/response port, then presents operands (X0, X1, base, scale, shift) to the downstream interpolation unit with a valid/ready handshake. It also keeps saturating counters of underflow and overflow hits.

Parameters:
LUT_DEPTH, 65, number of LUT entries; the maximum index is LUT_DEPTH-1.
LUT_AW, 7, LUT index width; ceil(log2(LUT_DEPTH)) is at most LUT_AW.

Ports:
nvdla_core_clk  in  1  core clock
nvdla_core_rst  in  1  asynchronous, active-high reset
smp_in_vld  in  1  sample valid
smp_in_rdy  out  1  sample ready
smp_in_pd  in  32  signed sample
cfg_start  in  32  signed LUT start
cfg_index_shift  in  5  index = (sample-start)>>shift
cfg_out_shift  in  6  signed shift passed to the interpolation unit
cfg_cnt_clr  in  1  pulse; clears both counters
lut_req_vld  out  1  LUT read request valid
lut_req_rdy  in  1  LUT read request ready
lut_req_idx0  out  LUT_AW  lower index
lut_req_idx1  out  LUT_AW  upper index
lut_rsp_vld  in  1  LUT data valid
lut_rsp_rdy  out  1  LUT data ready
lut_rsp_data0  in  16  signed entry[idx0]
lut_rsp_data1  in  16  signed entry[idx1]
interp_in_vld  out  1  operand valid
interp_in_rdy  in  1  operand ready
interp_in0_pd  out  39  sign-extended data0
interp_in1_pd  out  38  sign-extended data1
interp_in_pd  out  17  sign-extended data0 (base)
interp_in_scale  out  17  {1'b0, frac[15:0]}
interp_in_shift  out  6  cfg_out_shift captured at sample accept
interp_in_uflow  out  1  this operand came from an underflow
interp_in_oflow  out  1  this operand came from an overflow
uflow_cnt  out  32  saturating underflow count
oflow_cnt  out  32  saturating overflow count

Behaviour:
- Reset: state IDLE; all outputs 0, except smp_in_rdy = 1 once out of reset. Counters are 0.
- Reset mid-operation aborts the transaction with no output. The LUT side is reset together with this block, so no stale response is possible.
- FSM states: IDLE, REQ, WAIT, OUT. One transaction outstanding at a time.
- IDLE:
  - smp_in_rdy = 1.
  - On smp_in_vld, capture the sample and all cfg_* inputs, compute index and fraction, and go to REQ.
  - cfg changes after acceptance do not affect the in-flight transaction.
- Index math:
  - diff = sample - start, 33-bit signed.
  - diff < 0: underflow; idx0 = idx1 = 0, frac = 0.
  - Otherwise: raw = diff >> cfg_index_shift; frac = ({diff,16'b0} >> cfg_index_shift)[15:0]. shift = 0 gives frac = 0.
  - raw >= LUT_DEPTH-1: overflow; idx0 = idx1 = LUT_DEPTH-1, frac = 0.
  - Else idx0 = raw, idx1 = raw+1.
- REQ: lut_req_vld = 1 and idx0/idx1 are held stable until lut_req_rdy. On the handshake go to WAIT.
- WAIT: lut_rsp_rdy = 1. On lut_rsp_vld, register the operands and go to OUT.
  - lut_rsp_rdy = 0 in every other state.
- OUT:
  - interp_in_vld = 1; all interp_in_* outputs are held stable until interp_in_rdy.
  - On the handshake go to IDLE.
  - On the same cycle, uflow_cnt/oflow_cnt increment if this operand is an underflow/overflow.
- Minimum latency, with all readies high: sample accepted at cycle T, lut_req_vld at T+1, response accepted at T+2 (given lut_rsp_vld at T+2), interp_in_vld at T+3, smp_in_rdy again at T+4.
- Counters saturate at 32'hFFFFFFFF. If cfg_cnt_clr and an increment occur in the same cycle, the clear wins and the counter becomes 0.
- An early lut_rsp_vld while in REQ is ignored: rdy = 0.

Test Plan:
- start=0, index_shift=4, sample=0x35, LUT entry[3]=100, entry[4]=200 -> req idx0=3, idx1=4; frac=0x5000; scale=0x05000; in0=100, in1=200, in_pd=100; shift=cfg_out_shift; uflow=oflow=0.
- start=0x100, sample=0x80 -> idx0=idx1=0, scale=0, interp_in_uflow=1, uflow_cnt goes 0->1 at the output handshake.
- start=0, index_shift=0, sample=1000, LUT_DEPTH=65 -> idx0=idx1=64, scale=0, interp_in_oflow=1, oflow_cnt increments.
- Backpressure: lut_req_rdy low for 5 cycles, then interp_in_rdy low for 3 cycles -> request idx and operands stay stable throughout; smp_in_rdy stays 0 until the OUT handshake. Entry -5 gives in0_pd=39'h7FFFFFFFFB.
- Assert reset while in WAIT -> next cycle all outputs are 0, state IDLE; no interp_in_vld is produced for that sample; a new sample completes normally.
- Force uflow_cnt to 0xFFFFFFFF, then run another underflow -> count stays 0xFFFFFFFF; cfg_cnt_clr in the same cycle as an increment -> count becomes 0.
